gb_stencil_tx: RTL and testbench

Output end of the Gaussian-blur pipeline. It drains 3x3 stencils from the line-buffer stage and applies the fixed 1-2-1 binomial kernel to each. It transmits one blurred 8-bit pixel per stencil on the arg_0 AXI-stream master (TDATA/TVALID/TREADY, plus TLAST at end of frame).
Between input and output sit a 2-entry stencil FIFO (buff_0/buff_1, empty/full) and a single registered output slot.

---
 rtl/gb_pkg.sv | 40 ++++
 rtl/gb_stream_fifo2.sv | 64 ++++++
 rtl/gb_stencil_tx.sv | 105 ++++++++++
 tb/tb_gb_stencil_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the Gaussian-blur output stage.
// Holds the stencil geometry, the 1-2-1 binomial kernel, the normalisation
// shift, the default frame size and the kernel arithmetic function.
package gb_pkg;
    localparam int PIX_W       = 8;
    localparam int STENCIL_DIM = 3;
    localparam int STENCIL_W   = PIX_W * STENCIL_DIM * STENCIL_DIM;  // 72
    localparam int SUM_W       = 12;                                 // max 16*255 = 4080
    localparam int NORM_SHIFT  = 4;                                  // kernel weights sum to 16
    localparam int X_W         = 9;
    localparam int Y_W         = 10;
    localparam int DEF_OUT_W   = 480;
    localparam int DEF_OUT_H   = 640;

    localparam logic [STENCIL_DIM-1:0][1:0] KERN = {2'd1, 2'd2, 2'd1};

    // One output beat held in the registered output slot.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             last;
    } beat_t;

    // Separable 1-2-1 x 1-2-1 kernel with round-to-nearest. The result fits
    // in PIX_W bits for every input, so no saturation is needed.
    function automatic logic [PIX_W-1:0] blur3x3(input logic [STENCIL_W-1:0] s);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] w;
        logic [SUM_W-1:0] p;
        sum = '0;
        for (int r = 0; r < STENCIL_DIM; r++) begin
            for (int c = 0; c < STENCIL_DIM; c++) begin
                w   = SUM_W'(KERN[r]) * SUM_W'(KERN[c]);
                p   = SUM_W'(s[PIX_W*(STENCIL_DIM*r+c) +: PIX_W]);
                sum = sum + w * p;
            end
        end
        sum = sum + SUM_W'(1 << (NORM_SHIFT - 1));
        return sum[NORM_SHIFT +: PIX_W];
    endfunction
endpackage

// File: rtl/gb_stream_fifo2.sv
// Two-entry stream FIFO. buff_0 is always the head; buff_1 holds the second
// entry when full. Pushes while full and pops while empty are ignored.
// Ports: clk/rst (async high), push/push_data, pop, head_data, empty, full.
module gb_stream_fifo2 #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] buff_0_q, buff_0_d;
    logic [W-1:0] buff_1_q, buff_1_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         do_push, do_pop;

    assign do_push   = push & ~full_q;
    assign do_pop    = pop & ~empty_q;
    assign head_data = buff_0_q;
    assign empty     = empty_q;
    assign full      = full_q;

    always_comb begin
        buff_0_d = buff_0_q;
        buff_1_d = buff_1_q;
        empty_d  = empty_q;
        full_d   = full_q;
        if (do_push && do_pop) begin
            // only reachable with exactly one entry: replace the head
            buff_0_d = push_data;
        end else if (do_pop) begin
            buff_0_d = buff_1_q;
            full_d   = 1'b0;
            empty_d  = ~full_q;
        end else if (do_push) begin
            if (empty_q) begin
                buff_0_d = push_data;
                empty_d  = 1'b0;
            end else begin
                buff_1_d = push_data;
                full_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buff_0_q <= '0;
            buff_1_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            buff_0_q <= buff_0_d;
            buff_1_q <= buff_1_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end
endmodule

// File: rtl/gb_stencil_tx.sv
// Output end of the Gaussian-blur pipeline. Buffers 3x3 stencils in a
// 2-entry FIFO, blurs the head with the 1-2-1 kernel and sends one 8-bit
// pixel per stencil on the arg_0 AXI-stream master with TLAST at frame end.
// Ports: stencil_in_* (input stream), arg_0_* (AXI-stream out), FIFO status,
// out_x/out_y (position of the next pixel to emit), frame_done pulse.
module gb_stencil_tx
    import gb_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int OUT_H = DEF_OUT_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STENCIL_W-1:0] stencil_in_data,
    input  logic                 stencil_in_valid,
    output logic                 stencil_in_ready,
    output logic [PIX_W-1:0]     arg_0_TDATA,
    output logic                 arg_0_TVALID,
    output logic                 arg_0_TLAST,
    input  logic                 arg_0_TREADY,
    output logic                 stencil_stream_empty,
    output logic                 stencil_stream_full,
    output logic [X_W-1:0]       out_x,
    output logic [Y_W-1:0]       out_y,
    output logic                 frame_done
);
    localparam logic [X_W-1:0] X_LAST = X_W'(OUT_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(OUT_H - 1);

    logic [STENCIL_W-1:0] head;
    logic                 slot_free, fifo_pop, hs;
    beat_t                beat_q, beat_d;
    logic                 tvalid_q, tvalid_d;
    logic [X_W-1:0]       out_x_q, out_x_d, x_nxt, ld_x;
    logic [Y_W-1:0]       out_y_q, out_y_d, y_nxt, ld_y;

    assign stencil_in_ready = ~stencil_stream_full;
    assign hs               = tvalid_q & arg_0_TREADY;
    assign slot_free        = ~tvalid_q | arg_0_TREADY;
    assign fifo_pop         = slot_free & ~stencil_stream_empty;

    gb_stream_fifo2 #(.W(STENCIL_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stencil_in_valid & stencil_in_ready),
        .push_data (stencil_in_data),
        .pop       (fifo_pop),
        .head_data (head),
        .empty     (stencil_stream_empty),
        .full      (stencil_stream_full)
    );

    // Raster successor of the current position.
    always_comb begin
        x_nxt = out_x_q + X_W'(1);
        y_nxt = out_y_q;
        if (out_x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = (out_y_q == Y_LAST) ? '0 : out_y_q + Y_W'(1);
        end
    end

    always_comb begin
        // A beat loaded while the slot is still valid follows the beat that
        // is handshaking this edge, so its position is one step ahead.
        ld_x     = tvalid_q ? x_nxt : out_x_q;
        ld_y     = tvalid_q ? y_nxt : out_y_q;
        beat_d   = beat_q;
        tvalid_d = tvalid_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        if (fifo_pop) begin
            beat_d.data = blur3x3(head);
            beat_d.last = (ld_x == X_LAST) && (ld_y == Y_LAST);
            tvalid_d    = 1'b1;
        end else if (slot_free) begin
            tvalid_d = 1'b0;
        end
        if (hs) begin
            out_x_d = x_nxt;
            out_y_d = y_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q   <= '0;
            tvalid_q <= 1'b0;
            out_x_q  <= '0;
            out_y_q  <= '0;
        end else begin
            beat_q   <= beat_d;
            tvalid_q <= tvalid_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
        end
    end

    assign arg_0_TDATA  = beat_q.data;
    assign arg_0_TLAST  = beat_q.last;
    assign arg_0_TVALID = tvalid_q;
    assign out_x        = out_x_q;
    assign out_y        = out_y_q;
    assign frame_done   = hs & beat_q.last;
endmodule

// File: tb/tb_gb_stencil_tx.sv
// Directed bench for gb_stencil_tx with a 4x2 frame.
module tb_gb_stencil_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tready;
    logic        empty, full;
    logic [8:0]  ox;
    logic [9:0]  oy;
    logic        fdone;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    gb_stencil_tx #(.OUT_W(4), .OUT_H(2)) dut (
        .clk(clk), .rst(rst),
        .stencil_in_data(s_data), .stencil_in_valid(s_valid), .stencil_in_ready(s_ready),
        .arg_0_TDATA(tdata), .arg_0_TVALID(tvalid), .arg_0_TLAST(tlast), .arg_0_TREADY(tready),
        .stencil_stream_empty(empty), .stencil_stream_full(full),
        .out_x(ox), .out_y(oy), .frame_done(fdone)
    );

    function automatic logic [71:0] st_all(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] st_px(input int idx, input logic [7:0] v);
        logic [71:0] s;
        s = '0;
        s[8*idx +: 8] = v;
        return s;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_data = '0; tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; tready = 1'b0;
        #2;
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %0b want 0", tvalid); end
        n_cmp++; if (tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got %h want 00", tdata); end
        n_cmp++; if (tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %0b want 0", tlast); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b want 0", full); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", s_ready); end
        n_cmp++; if (ox !== 9'd0 || oy !== 10'd0) begin n_err++; $display("FAIL rst_xy got %0d/%0d want 0/0", ox, oy); end
        n_cmp++; if (fdone !== 1'b0) begin n_err++; $display("FAIL rst_fdone got %0b want 0", fdone); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        apply_reset();
        tready = 1'b1;
        s_data = st_all(8'h10); s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL lat_early_tvalid got %0b want 0", tvalid); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL lat_empty got %0b want 0", empty); end
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL lat_tvalid got %0b want 1", tvalid); end
        n_cmp++; if (tdata !== 8'h10) begin n_err++; $display("FAIL lat_tdata got %h want 10", tdata); end
        n_cmp++; if (tlast !== 1'b0 || ox !== 9'd0) begin n_err++; $display("FAIL lat_pos got last=%0b x=%0d want 0/0", tlast, ox); end
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL lat_drain got %0b want 0", tvalid); end
        n_cmp++; if (ox !== 9'd1) begin n_err++; $display("FAIL lat_x_adv got %0d want 1", ox); end
    endtask

    task automatic test_kernel();
        logic [71:0] vin [6];
        logic [7:0]  vexp[6];
        vin[0] = st_px(4, 8'hFF);                                    vexp[0] = 8'h40;
        vin[1] = st_all(8'hFF);                                      vexp[1] = 8'hFF;
        vin[2] = st_px(0, 8'hFF) | st_px(2, 8'hFF) | st_px(6, 8'hFF) | st_px(8, 8'hFF); vexp[2] = 8'h40;
        vin[3] = st_px(0, 8'h80) | st_px(1, 8'h80) | st_px(2, 8'h80); vexp[3] = 8'h20;
        vin[4] = st_px(1, 8'h04);                                    vexp[4] = 8'h01;
        vin[5] = st_px(4, 8'h01);                                    vexp[5] = 8'h00;
        apply_reset();
        tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = vin[i]; s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== vexp[i]) begin
                n_err++; $display("FAIL kern_%0d got v=%0b d=%h want v=1 d=%h", i, tvalid, tdata, vexp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tready = 1'b0;
        s_data = st_all(8'h10); s_valid = 1'b1; @(negedge clk);   // A
        s_data = st_all(8'h20); @(negedge clk);                   // B
        s_data = st_all(8'h30); @(negedge clk);                   // C
        s_data = st_all(8'h40);                                   // D offered
        n_cmp++; if (full !== 1'b1 || s_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got full=%0b rdy=%0b want 1/0", full, s_ready); end
        n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h10) begin n_err++; $display("FAIL bp_hold got v=%0b d=%h want 1/10", tvalid, tdata); end
        @(negedge clk);
        n_cmp++; if (tdata !== 8'h10 || full !== 1'b1) begin n_err++; $display("FAIL bp_stable got d=%h full=%0b want 10/1", tdata, full); end
        tready = 1'b1;
        @(negedge clk);
        n_cmp++; if (tdata !== 8'h20 || s_ready !== 1'b1) begin n_err++; $display("FAIL bp_b got d=%h rdy=%0b want 20/1", tdata, s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++; if (tdata !== 8'h30 || tvalid !== 1'b1) begin n_err++; $display("FAIL bp_c got d=%h v=%0b want 30/1", tdata, tvalid); end
        @(negedge clk);
        n_cmp++; if (tdata !== 8'h40 || tvalid !== 1'b1) begin n_err++; $display("FAIL bp_d got d=%h v=%0b want 40/1", tdata, tvalid); end
        n_cmp++; if (ox !== 9'd3 || oy !== 10'd0 || tlast !== 1'b0) begin n_err++; $display("FAIL bp_d_pos got %0d/%0d last=%0b want 3/0/0", ox, oy, tlast); end
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b0 || ox !== 9'd0 || oy !== 10'd1) begin n_err++; $display("FAIL bp_end got v=%0b %0d/%0d want 0 0/1", tvalid, ox, oy); end
    endtask

    task automatic test_frame();
        apply_reset();
        tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                int b;
                b = c - 1;
                n_cmp++;
                if (tvalid !== 1'b1 || tdata !== 8'(b) || tlast !== (b == 8) || fdone !== (b == 8)
                    || ox !== 9'((b - 1) % 4) || oy !== 10'((b - 1) / 4)) begin
                    n_err++;
                    $display("FAIL frame_beat%0d got v=%0b d=%h last=%0b fd=%0b xy=%0d/%0d want 1 %h %0b %0b %0d/%0d",
                             b, tvalid, tdata, tlast, fdone, ox, oy, 8'(b), b == 8, b == 8, (b - 1) % 4, (b - 1) / 4);
                end
            end
            if (c < 8) begin
                s_data = st_all(8'(c + 1)); s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (tvalid !== 1'b0 || fdone !== 1'b0 || ox !== 9'd0 || oy !== 10'd0) begin
            n_err++; $display("FAIL frame_wrap got v=%0b fd=%0b xy=%0d/%0d want 0 0 0/0", tvalid, fdone, ox, oy); end
        s_data = st_all(8'h09); s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h09 || tlast !== 1'b0 || ox !== 9'd0 || oy !== 10'd0) begin
            n_err++; $display("FAIL frame_next got v=%0b d=%h last=%0b xy=%0d/%0d want 1 09 0 0/0", tvalid, tdata, tlast, ox, oy); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        tready = 1'b1;
        s_data = st_all(8'h11); s_valid = 1'b1; @(negedge clk);
        s_data = st_all(8'h22); @(negedge clk);
        s_data = st_all(8'h33); @(negedge clk);
        tready = 1'b0;                                  // 0x22 stalled in slot
        s_data = st_all(8'h44); @(negedge clk);
        s_valid = 1'b0;
        n_cmp++; if (full !== 1'b1 || tvalid !== 1'b1 || ox !== 9'd1) begin
            n_err++; $display("FAIL mid_pre got full=%0b v=%0b x=%0d want 1 1 1", full, tvalid, ox); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tvalid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rst got v=%0b e=%0b f=%0b rdy=%0b want 0 1 0 1", tvalid, empty, full, s_ready); end
        n_cmp++; if (ox !== 9'd0 || oy !== 10'd0) begin n_err++; $display("FAIL mid_rst_xy got %0d/%0d want 0/0", ox, oy); end
        @(negedge clk);
        rst = 1'b0; tready = 1'b1;
        s_data = st_all(8'h5A); s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b1 || tdata !== 8'h5A || ox !== 9'd0 || oy !== 10'd0) begin
            n_err++; $display("FAIL mid_after got v=%0b d=%h xy=%0d/%0d want 1 5a 0/0", tvalid, tdata, ox, oy); end
        @(negedge clk);
        n_cmp++; if (tvalid !== 1'b0 || ox !== 9'd1) begin n_err++; $display("FAIL mid_drain got v=%0b x=%0d want 0 1", tvalid, ox); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_kernel();
        test_back_to_back();
        test_frame();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
